// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: streams operand bit pairs LSB first through a
// single one-bit full adder, with the carry fed back through a register.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    count_q, count_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        count_d  = count_q + CW'(1);
        // Separate cout register keeps the final carry stable in IDLE even
        // after the next start reloads carry_q with the new carry-in.
        if (count_q == LAST) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomised checks of bit_serial_adder at WIDTH=8 and WIDTH=16.

module tb_bit_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  logic        cinv = 1'b0;

  logic        busy8, done8, cout8;
  logic [7:0]  result8;
  logic        busy16, done16, cout16;
  logic [15:0] result16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .op_a   (opa[7:0]),
    .op_b   (opb[7:0]),
    .cin    (cinv),
    .busy   (busy8),
    .done   (done8),
    .result (result8),
    .cout   (cout8)
  );

  bit_serial_adder #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .start  (start16),
    .op_a   (opa),
    .op_b   (opb),
    .cin    (cinv),
    .busy   (busy16),
    .done   (done16),
    .result (result16),
    .cout   (cout16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launches one addition and watches WIDTH+3 cycles after the accepting edge.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        input logic c, output logic [15:0] res, output logic co,
                        output int done_at, output int pulses, output int busy_cycles,
                        output int overlap, output logic [15:0] res_end);
    int w;
    logic bsy, dn, cr;
    logic [15:0] rs;
    w = w16 ? 16 : 8;
    res = '0; co = 1'b0; done_at = -1; pulses = 0; busy_cycles = 0; overlap = 0;
    @(negedge clk);
    opa = a; opb = b; cinv = c;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= w + 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start8 = 1'b0; start16 = 1'b0;
        opa = ~a; opb = ~b; cinv = ~c;
      end
      bsy = w16 ? busy16 : busy8;
      dn  = w16 ? done16 : done8;
      rs  = w16 ? result16 : {8'h00, result8};
      cr  = w16 ? cout16 : cout8;
      if (bsy) busy_cycles++;
      if (bsy && dn) overlap++;
      if (dn) begin
        pulses++;
        if (done_at < 0) begin
          done_at = i; res = rs; co = cr;
        end
      end
      res_end = rs;
    end
  endtask

  task automatic add_and_check(input string tag, input bit w16, input logic [15:0] a,
                               input logic [15:0] b, input logic c);
    logic [16:0] exp;
    logic [15:0] res, res_end;
    logic co;
    int done_at, pulses, busy_cycles, overlap, w;
    w = w16 ? 16 : 8;
    exp = w16 ? ({1'b0, a} + {1'b0, b} + {16'h0, c})
              : {8'h00, ({1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, c})};
    run_op(w16, a, b, c, res, co, done_at, pulses, busy_cycles, overlap, res_end);
    if (w16) begin
      check({tag, " result"}, {16'h0, res}, {16'h0, exp[15:0]});
      check({tag, " cout"}, {31'h0, co}, {31'h0, exp[16]});
    end else begin
      check({tag, " result"}, {16'h0, res}, {24'h0, exp[7:0]});
      check({tag, " cout"}, {31'h0, co}, {31'h0, exp[8]});
    end
    check({tag, " done_at"}, done_at, w + 1);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " busy_cycles"}, busy_cycles, w);
    check({tag, " overlap"}, overlap, 0);
    check({tag, " hold"}, {16'h0, res_end}, {16'h0, res});
    $display("[TB] %s w=%0d a=%0h b=%0h cin=%0d -> result=%0h cout=%0d done_at=%0d",
             tag, w, a, b, c, res, co, done_at);
  endtask

  initial begin
    int k;
    logic [15:0] ra, rb;
    logic rc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", {31'h0, busy8}, 0);
    check("rst done", {31'h0, done8}, 0);
    check("rst result", {24'h0, result8}, 0);
    check("rst cout", {31'h0, cout8}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", {31'h0, busy8}, 0);

    add_and_check("3C+5A", 1'b0, 16'h3C, 16'h5A, 1'b0);
    check("3C+5A exact", {24'h0, result8}, 32'h96);
    add_and_check("FF+01", 1'b0, 16'hFF, 16'h01, 1'b0);
    check("FF+01 exact", {23'h0, cout8, result8}, 32'h100);
    add_and_check("FF+FF+1", 1'b0, 16'hFF, 16'hFF, 1'b1);
    check("FF+FF+1 exact", {23'h0, cout8, result8}, 32'h1FF);

    // start held high and operands changed while busy; start high in DONE
    @(negedge clk);
    opa = 16'h12; opb = 16'h34; cinv = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opa = 16'hAA; opb = 16'h55; cinv = 1'b1;
    k = 1;
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("held done_at", k, 9);
    check("held result", {24'h0, result8}, 32'h46);
    check("held cout", {31'h0, cout8}, 0);
    @(negedge clk);
    check("start in DONE busy", {31'h0, busy8}, 0);
    check("start in DONE done", {31'h0, done8}, 0);
    check("start in DONE result", {24'h0, result8}, 32'h46);
    start8 = 1'b0;
    add_and_check("after DONE 01+02", 1'b0, 16'h01, 16'h02, 1'b0);

    // Reset at shift 4 aborts the operation
    @(negedge clk);
    opa = 16'hF0; opb = 16'h0F; cinv = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", {31'h0, busy8}, 0);
    check("abort done", {31'h0, done8}, 0);
    check("abort result", {24'h0, result8}, 0);
    check("abort cout", {31'h0, cout8}, 0);
    @(negedge clk);
    rst = 1'b0;
    add_and_check("post-abort 01+01", 1'b0, 16'h01, 16'h01, 1'b0);

    // Back-to-back: no carry leaks between operations
    add_and_check("80+80", 1'b0, 16'h80, 16'h80, 1'b0);
    add_and_check("00+00+1", 1'b0, 16'h00, 16'h00, 1'b1);
    check("b2b exact", {23'h0, cout8, result8}, 32'h001);

    add_and_check("w16 FFFF+0001", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    add_and_check("w16 1234+4321+1", 1'b1, 16'h1234, 16'h4321, 1'b1);

    for (int n = 0; n < 600; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      add_and_check("rand8", 1'b0, ra, rb, rc);
    end
    for (int n = 0; n < 600; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      add_and_check("rand16", 1'b1, ra, rb, rc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the team's existing one-bit full adder (full_adder, a/b/cin -> sum/cout).
- Sits directly upstream of the full adder and feeds it one operand bit pair per clock, LSB first.
- Registers the carry-out back into the full adder's carry-in each cycle.
- Collects the sum bits in a result shift register and signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the accepted start edge.
- op_b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  initial carry-in; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  high for exactly one cycle, in DONE.
- result  output  WIDTH  sum; valid from DONE until the next accepted start.
- cout  output  1  final carry-out; same validity as result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - A/B shift registers, carry register, bit counter and result register all cleared to 0.
  - Outputs: busy=0, done=0, result=0, cout=0.
- Reset asserted mid-operation aborts the addition at once; no done pulse is produced.
- The FSM has three states, IDLE, SHIFT and DONE, with registered state.
- IDLE:
  - On a clk edge with start=1: load op_a and op_b into the shift registers, carry_reg<=cin, count<=0, go to SHIFT.
  - result and cout hold their previous values until the first shift edge.
- SHIFT, on each edge:
  - The full_adder instance sees a=A[0], b=B[0], cin=carry_reg.
  - result <= {fa_sum, result[WIDTH-1:1]} (shift right, sum bit enters at the MSB).
  - carry_reg <= fa_cout.
  - A and B shift right by 1, with 0 filled in at the MSB.
  - count <= count+1.
  - When count==WIDTH-1 on that edge, go to DONE.
- DONE:
  - done=1 and busy=0.
  - result holds the full sum and cout=carry_reg.
  - The next edge goes unconditionally to IDLE.
- Latency: with start accepted at edge t, shifts occur at edges t+1..t+WIDTH, and done is high in the cycle following edge t+WIDTH.
- Throughput: one addition per WIDTH+2 cycles at best.
- start is ignored in SHIFT and in DONE; there is no queuing. op_a, op_b and cin may change freely after the accepted start edge.
- The counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.
- Arithmetic: the block computes {cout,result} = op_a + op_b + cin, unsigned, WIDTH+1 bits, with no overflow flag.
- result and cout keep their final values in IDLE until the next accepted start.
- busy and done are never high together.

Test Plan:
- WIDTH=8, op_a=0x3C, op_b=0x5A, cin=0, start pulse -> busy high for 8 cycles, then done pulses once, result=0x96, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 -> result=0x00, cout=1; 0xFF+0xFF with cin=1 -> result=0xFF, cout=1.
- start held high and operands changed while busy -> ignored; result is still from the originally captured operands. start high in the DONE cycle -> ignored, and the next start in IDLE is accepted normally.
- rst asserted at shift 4 of an operation -> outputs immediately 0 and state IDLE; after release, a new start with 0x01+0x01 -> result 0x02, and exactly one done pulse.
- Back-to-back operations (0x80+0x80 cin0, then 0x00+0x00 cin1) -> first gives result 0x00, cout 1; second gives result 0x01, cout 0. No carry leaks between operations.
- Random sweep (>=1000 vectors, WIDTH=8 and WIDTH=16) against a reference op_a+op_b+cin model. Also checks done spacing of WIDTH+1 cycles after start, and that busy and done are never high together.
